udp_rx_demux: RTL
=================

UDP_RX_DEMUX -- requirements
Module: udp_rx_demux

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of output channels (1..8).
REQ-002 SHALL have parameter DW, default 16: output word width; a multiple of 8, from 8 to 64.
REQ-003 SHALL have parameter DEPTH, default 64: words per channel buffer; a power of two.
REQ-004 SHALL have parameter MY_IP, default 32'h12_12_6b_0d: local IPv4 address.
REQ-005 SHALL have ports: clk input 1, the clock; rst input 1, the reset (synchronous, active-high).
REQ-006 SHALL have ports in_valid input 1 and in_data input 8: payload byte stream.
REQ-007 SHALL have ports in_sof input 1 and in_eof input 1: first and last byte markers, qualified by in_valid.
REQ-008 SHALL have port in_good input 1: frame passed CRC/checksum; sampled only with in_eof.
REQ-009 SHALL have ports hdr_dst_ip input 32 and hdr_dst_port input 16: header fields, sampled with in_sof.
REQ-010 SHALL have port cfg_port input NUM_CH*16: per-channel UDP port; a value of 0 disables that channel.
REQ-011 SHALL have ports out_valid output NUM_CH, out_ready input NUM_CH, out_data output NUM_CH*DW and out_last output NUM_CH: per-channel FWFT stream.

Function
REQ-012 SHALL use a 3-state FSM: IDLE, ACCEPT, DISCARD.
REQ-013 SHALL select a channel on in_valid&&in_sof in any state when both hold:
- hdr_dst_ip is MY_IP or 32'hFFFF_FFFF;
- hdr_dst_port equals a nonzero cfg_port entry.
The lowest matching index wins. Target ACCEPT; otherwise DISCARD.
REQ-014 SHALL pack bytes into DW words big-endian (first byte in the MSBs) and write a word to the selected buffer's speculative write pointer when it fills or on in_eof.
REQ-015 SHALL zero-pad a partial final word and set its last flag.
REQ-016 SHALL, on in_eof with in_good=1 in ACCEPT, copy the speculative pointer to the committed pointer; words become visible on out_valid the next cycle. Next state IDLE.
REQ-017 SHALL, on in_eof with in_good=0, restore the speculative pointer to the committed pointer (rollback). Next state IDLE.
REQ-018 SHALL, on a word write into a full buffer, roll back and enter DISCARD until in_eof. The partial frame SHALL never be visible.
REQ-019 SHALL, on in_sof while in ACCEPT (missing eof), roll back the open frame, then evaluate the new frame per REQ-013 in the same cycle.
REQ-020 SHALL ignore in_valid bytes in IDLE that lack in_sof.
REQ-021 SHALL drop all bytes in DISCARD; in_eof returns to IDLE.
REQ-022 SHALL set out_valid[i] = (committed pointer != read pointer) for channel i.
REQ-023 SHALL present out_data and out_last for the word at the read pointer; out_valid&&out_ready advances the read pointer by one.
REQ-024 SHALL use pointers of log2(DEPTH)+1 bits; full and empty are distinguished by the MSB; wrap-around is modulo 2*DEPTH.
REQ-025 SHALL compute full against the read pointer; a read and a write in the same cycle on one channel are both honoured.
REQ-026 SHALL sample cfg_port only at in_sof; changes mid-frame do not affect the open frame.
REQ-027 SHALL treat in_sof&&in_eof on one byte as a complete one-word frame.

Reset
REQ-028 SHALL, on rst, set the FSM to IDLE and clear all pointers, the pack register and the byte counter.
REQ-029 SHALL hold out_valid=0, out_data=0 and out_last=0 during and after reset until a commit.
REQ-030 SHALL discard all buffered and in-flight frames on rst asserted mid-frame; bytes after reset release are ignored until the next in_sof.

Configuration
REQ-031 SHALL, with RX_DROP_STATS_EN defined, provide output drop_count NUM_CH*16: per-channel saturating counters.
- Increment on rollback from bad CRC, overflow or missing eof.
- Cleared by rst.
REQ-032 SHALL, without RX_DROP_STATS_EN, omit port drop_count and its logic entirely.

Verification
REQ-033 SHALL cover: ch0 port 5000, dst MY_IP, 5 bytes 01..05, good -> ch0 words 0x0102, 0x0304, 0x0500 (last=1); out_valid rises 1 cycle after eof.
REQ-034 SHALL cover: dst 10.0.0.1 or unmatched port 7 -> no out_valid on any channel; FSM passes through DISCARD.
REQ-035 SHALL cover: 6 good bytes then eof with in_good=0 -> out_valid stays 0, write pointer restored, drop_count[0]=1 (with macro).
REQ-036 SHALL cover: DEPTH=4, 10-byte frame, out_ready=0 -> frame dropped; an earlier committed 2-word frame is still read intact.
REQ-037 SHALL cover: both channels set to port 80 -> traffic lands on ch0 only.
REQ-038 SHALL cover: ch1 frame committed while ch0 is being read with out_ready toggling -> no word lost or duplicated; rst mid-frame -> all out_valid=0.

Source files
------------

// File: rtl/udp_rx_demux.sv
// udp_rx_demux: steers a UDP payload byte stream into per-channel FWFT word buffers and exposes only whole, good frames.
// Define RX_DROP_STATS_EN to add the per-channel saturating drop_count output.
module udp_rx_demux #(
  parameter int          NUM_CH = 2,
  parameter int          DW     = 16,
  parameter int          DEPTH  = 64,
  parameter logic [31:0] MY_IP  = 32'h12_12_6b_0d
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic                 in_good,
  input  logic [31:0]          hdr_dst_ip,
  input  logic [15:0]          hdr_dst_port,
  input  logic [NUM_CH*16-1:0] cfg_port,
  output logic [NUM_CH-1:0]    out_valid,
  input  logic [NUM_CH-1:0]    out_ready,
  output logic [NUM_CH*DW-1:0] out_data,
  output logic [NUM_CH-1:0]    out_last
`ifdef RX_DROP_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] drop_count
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int BPW = DW / 8;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   sel;
  logic [DW-1:0]   pack;
  logic [BW-1:0]   cnt;
  logic [PW-1:0]   wr_spec [NUM_CH];
  logic [PW-1:0]   wr_com  [NUM_CH];
  logic [PW-1:0]   rd      [NUM_CH];
  logic [DW:0]     mem     [NUM_CH][DEPTH];

  logic            match;
  logic [CW-1:0]   match_ch;
  logic            sof_hit, active, do_write, is_full, overflow, wr_ok;
  logic            commit, roll_new, abort_old;
  logic [CW-1:0]   cur_ch;
  logic [BW-1:0]   cur_cnt;
  logic [DW-1:0]   word;
  logic [PW-1:0]   base, rd_cur;

  // Descending scan so the lowest matching channel is the last assignment.
  always_comb begin
    match    = 1'b0;
    match_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_port[i*16 +: 16] != 16'd0 && cfg_port[i*16 +: 16] == hdr_dst_port) begin
        match    = 1'b1;
        match_ch = CW'(i);
      end
    end
    if (hdr_dst_ip != MY_IP && hdr_dst_ip != 32'hFFFF_FFFF)
      match = 1'b0;
  end

  // NOTE: every signal driven here gets a default first, so no latches are inferred.
  always_comb begin
    sof_hit   = in_valid && in_sof;
    cur_ch    = sof_hit ? match_ch : sel;
    active    = in_valid && (sof_hit ? match : (state == ACCEPT));
    cur_cnt   = sof_hit ? '0 : cnt;
    word      = (sof_hit ? '0 : pack) | (DW'(in_data) << (8 * (BPW - 1 - int'(cur_cnt))));
    do_write  = active && (in_eof || cur_cnt == BW'(BPW - 1));
    // A new frame always starts from the committed pointer of its channel.
    base      = sof_hit ? wr_com[cur_ch] : wr_spec[cur_ch];
    rd_cur    = rd[cur_ch];
    is_full   = (base[AW-1:0] == rd_cur[AW-1:0]) && (base[AW] != rd_cur[AW]);
    overflow  = do_write && is_full;
    wr_ok     = do_write && !is_full;
    commit    = active && in_eof && in_good && !is_full;
    roll_new  = active && (overflow || (in_eof && !in_good));
    abort_old = sof_hit && (state == ACCEPT);

    state_nx = state;
    if (in_valid) begin
      if (sof_hit || state == ACCEPT) begin
        if (in_eof)                  state_nx = IDLE;
        else if (active && !overflow) state_nx = ACCEPT;
        else                         state_nx = DISCARD;
      end else if (state == DISCARD && in_eof) begin
        state_nx = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      pack  <= '0;
      cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_spec[i] <= '0;
        wr_com[i]  <= '0;
        rd[i]      <= '0;
      end
    end else begin
      state <= state_nx;
      if (sof_hit) sel <= match_ch;
      if (active) begin
        pack <= do_write ? '0 : word;
        cnt  <= do_write ? '0 : cur_cnt + 1'b1;
      end else if (sof_hit) begin
        pack <= '0;
        cnt  <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_valid[i] && out_ready[i]) rd[i] <= rd[i] + 1'b1;
        if (abort_old && sel == CW'(i)) wr_spec[i] <= wr_com[i];
        if (cur_ch == CW'(i)) begin
          if (roll_new)   wr_spec[i] <= wr_com[i];
          else if (wr_ok) wr_spec[i] <= base + 1'b1;
          if (commit)     wr_com[i]  <= base + 1'b1;
        end
      end
    end
  end

  // NOTE: buffer storage is not reset; outputs are masked until a word is committed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[cur_ch][base[AW-1:0]] <= {in_eof, word};
  end

  always_comb begin
    logic [DW:0] head;
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      head = mem[i][rd[i][AW-1:0]];
      if (wr_com[i] != rd[i]) begin
        out_valid[i]           = 1'b1;
        out_data[i*DW +: DW]   = head[DW-1:0];
        out_last[i]            = head[DW];
      end
    end
  end

`ifdef RX_DROP_STATS_EN
  logic [15:0] drops    [NUM_CH];
  logic [1:0]  drop_inc [NUM_CH];

  // A missing-eof abort and a failed new frame can hit the same channel in one cycle.
  always_comb begin
    drop_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_inc[i] = 2'(abort_old && sel == CW'(i)) + 2'(roll_new && cur_ch == CW'(i));
      drop_count[i*16 +: 16] = drops[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst)
        drops[i] <= '0;
      else if (drops[i] > 16'hFFFF - 16'(drop_inc[i]))
        drops[i] <= 16'hFFFF;
      else
        drops[i] <= drops[i] + 16'(drop_inc[i]);
    end
  end
`endif

endmodule
